// File: rtl/instr_mem_pkg.sv
// Shared definitions for the instruction memory controller: state encoding and default geometry.
package instr_mem_pkg;

   localparam int unsigned IMEM_ADDR_W = 8;
   localparam int unsigned IMEM_DATA_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_RUN  = 2'b10
   } state_t;

endpackage

// File: rtl/instr_mem_ctrl.sv
// Arbitrates the instruction BRAM between a program loader (LOAD mode) and CPU fetch (RUN mode).
// Modes are exclusive, so the write and read ports are never active together.
module instr_mem_ctrl
   import instr_mem_pkg::*;
#(
   parameter int unsigned ADDR_W = IMEM_ADDR_W,
   parameter int unsigned DATA_W = IMEM_DATA_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_load_start,
   input  logic              i_load_valid,
   input  logic [DATA_W-1:0] i_load_data,
   input  logic              i_load_last,
   output logic              o_load_ready,
   output logic              o_load_done,
   output logic [ADDR_W:0]   o_load_count,
   input  logic              i_fetch_req,
   input  logic [ADDR_W-1:0] i_fetch_addr,
   output logic              o_fetch_ready,
   output logic              o_fetch_valid,
   output logic [DATA_W-1:0] o_fetch_instr,
   output logic              o_mem_en_write,
   output logic [ADDR_W-1:0] o_mem_addr_write,
   output logic [DATA_W-1:0] o_mem_instr_write,
   output logic [ADDR_W-1:0] o_mem_addr_read,
   input  logic [DATA_W-1:0] i_mem_instr_read,
   output logic [1:0]        o_state,
   output logic              o_cpu_run
);

   localparam int unsigned       CNT_W   = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] PTR_MAX = '1;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] wr_ptr;
   logic [CNT_W-1:0]  load_count;
   logic              load_done;
   logic              fetch_valid;
   logic [DATA_W-1:0] instr_hold;
   logic              load_acc;
   logic              load_end;
   logic              fetch_acc;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Mode sequencing plus the same-cycle BRAM port drive for accepted beats/fetches.
   always_comb begin
      state_nxt         = state;
      o_load_ready      = 1'b0;
      o_fetch_ready     = 1'b0;
      o_cpu_run         = 1'b0;
      load_acc          = 1'b0;
      load_end          = 1'b0;
      fetch_acc         = 1'b0;
      o_mem_en_write    = 1'b0;
      o_mem_addr_write  = '0;
      o_mem_instr_write = '0;
      o_mem_addr_read   = '0;

      case (state)
         ST_IDLE: begin
            if (i_load_start) state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            // A start pulse restarts the load and blocks the concurrent beat.
            o_load_ready = ~i_load_start;
            load_acc     = i_load_valid & ~i_load_start;
            load_end     = load_acc & (i_load_last | (wr_ptr == PTR_MAX));
            if (load_end) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            o_fetch_ready = 1'b1;
            o_cpu_run     = 1'b1;
            fetch_acc     = i_fetch_req;
            if (i_load_start) state_nxt = ST_LOAD;
         end
         default: state_nxt = ST_IDLE;
      endcase

      if (load_acc) begin
         o_mem_en_write    = 1'b1;
         o_mem_addr_write  = wr_ptr;
         o_mem_instr_write = i_load_data;
      end
      if (fetch_acc) o_mem_addr_read = i_fetch_addr;
   end

   // Write pointer, completed-load bookkeeping and the one-flop fetch tag.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr      <= '0;
         load_count  <= '0;
         load_done   <= 1'b0;
         fetch_valid <= 1'b0;
         instr_hold  <= '0;
      end else begin
         load_done   <= load_end;
         fetch_valid <= fetch_acc;
         if (fetch_valid) instr_hold <= i_mem_instr_read;
         if (i_load_start || load_end) wr_ptr <= '0;
         else if (load_acc)            wr_ptr <= wr_ptr + ADDR_W'(1);
         if (load_end) load_count <= {1'b0, wr_ptr} + CNT_W'(1);
      end
   end

   // BRAM data arrives registered, so it is passed straight through on the tagged cycle.
   assign o_fetch_instr = fetch_valid ? i_mem_instr_read : instr_hold;
   assign o_fetch_valid = fetch_valid;
   assign o_load_done   = load_done;
   assign o_load_count  = load_count;
   assign o_state       = state;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Bench for instr_mem_ctrl: directed vector table, corner sequences and random traffic vs a mode-level model.
module tb_instr_mem_ctrl;

   localparam int unsigned AW    = 8;
   localparam int unsigned DW    = 16;
   localparam int unsigned DEPTH = 256;

   logic          clk;
   logic          rst;
   logic          load_start;
   logic          load_valid;
   logic [DW-1:0] load_data;
   logic          load_last;
   logic          load_ready;
   logic          load_done;
   logic [AW:0]   load_count;
   logic          fetch_req;
   logic [AW-1:0] fetch_addr;
   logic          fetch_ready;
   logic          fetch_valid;
   logic [DW-1:0] fetch_instr;
   logic          mem_en_write;
   logic [AW-1:0] mem_addr_write;
   logic [DW-1:0] mem_instr_write;
   logic [AW-1:0] mem_addr_read;
   logic [DW-1:0] mem_instr_read;
   logic [1:0]    state;
   logic          cpu_run;

   instr_mem_ctrl dut (
      .i_clk             (clk),
      .i_rst             (rst),
      .i_load_start      (load_start),
      .i_load_valid      (load_valid),
      .i_load_data       (load_data),
      .i_load_last       (load_last),
      .o_load_ready      (load_ready),
      .o_load_done       (load_done),
      .o_load_count      (load_count),
      .i_fetch_req       (fetch_req),
      .i_fetch_addr      (fetch_addr),
      .o_fetch_ready     (fetch_ready),
      .o_fetch_valid     (fetch_valid),
      .o_fetch_instr     (fetch_instr),
      .o_mem_en_write    (mem_en_write),
      .o_mem_addr_write  (mem_addr_write),
      .o_mem_instr_write (mem_instr_write),
      .o_mem_addr_read   (mem_addr_read),
      .i_mem_instr_read  (mem_instr_read),
      .o_state           (state),
      .o_cpu_run         (cpu_run)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous BRAM with registered read data.
   logic [DW-1:0] bram [DEPTH];
   always @(posedge clk) begin
      if (mem_en_write) bram[mem_addr_write] <= mem_instr_write;
      mem_instr_read <= bram[mem_addr_read];
   end

   // Reference model: mode, load pointer, program image and the fetch value visible to the CPU.
   int            m_mode;
   int            m_ptr;
   int            m_count;
   bit            m_done;
   bit            m_fv;
   logic [DW-1:0] m_fi;
   logic [DW-1:0] exp_mem [DEPTH];
   bit            e_acc;
   bit            e_facc;

   int checks;
   int errors;

   typedef struct {
      logic          st;
      logic          lv;
      logic [DW-1:0] ld;
      logic          ll;
      logic          fr;
      logic [AW-1:0] fa;
      logic [1:0]    e_st;
      logic          e_rdy;
      logic          e_en;
      logic [AW-1:0] e_aw;
      logic          e_done;
      logic [AW:0]   e_cnt;
      logic [AW-1:0] e_ar;
      logic          e_fv;
      logic [DW-1:0] e_fi;
   } vec_t;

   vec_t vecs [10];

   function automatic vec_t mkv(input int st, input int lv, input int ld, input int ll,
                                input int fr, input int fa, input int e_st, input int e_rdy,
                                input int e_en, input int e_aw, input int e_done, input int e_cnt,
                                input int e_ar, input int e_fv, input int e_fi);
      vec_t v;
      v.st = 1'(st);  v.lv = 1'(lv);  v.ld = DW'(ld);  v.ll = 1'(ll);
      v.fr = 1'(fr);  v.fa = AW'(fa);
      v.e_st = 2'(e_st);  v.e_rdy = 1'(e_rdy);  v.e_en = 1'(e_en);  v.e_aw = AW'(e_aw);
      v.e_done = 1'(e_done);  v.e_cnt = (AW+1)'(e_cnt);  v.e_ar = AW'(e_ar);
      v.e_fv = 1'(e_fv);  v.e_fi = DW'(e_fi);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_ptr = 0; m_count = 0; m_done = 0; m_fv = 0; m_fi = '0;
   endtask

   // Drive one cycle of inputs after the falling edge and compare every output with the model.
   task automatic drive(input bit st, input bit lv, input logic [DW-1:0] ld, input bit ll,
                        input bit fr, input logic [AW-1:0] fa);
      bit e_ready;
      bit e_fready;
      @(negedge clk);
      load_start = st; load_valid = lv; load_data = ld; load_last = ll;
      fetch_req  = fr; fetch_addr = fa;
      #1;
      e_ready  = (m_mode == 1) && !st;
      e_acc    = lv && e_ready;
      e_fready = (m_mode == 2);
      e_facc   = fr && e_fready;
      chk("state",           32'(state),           32'(m_mode));
      chk("load_ready",      32'(load_ready),      32'(e_ready));
      chk("mem_en_write",    32'(mem_en_write),    32'(e_acc));
      chk("mem_addr_write",  32'(mem_addr_write),  e_acc ? 32'(m_ptr) : 32'd0);
      chk("mem_instr_write", 32'(mem_instr_write), e_acc ? 32'(ld) : 32'd0);
      chk("fetch_ready",     32'(fetch_ready),     32'(e_fready));
      chk("cpu_run",         32'(cpu_run),         32'(e_fready));
      chk("mem_addr_read",   32'(mem_addr_read),   e_facc ? 32'(fa) : 32'd0);
      chk("fetch_valid",     32'(fetch_valid),     32'(m_fv));
      chk("fetch_instr",     32'(fetch_instr),     32'(m_fi));
      chk("load_done",       32'(load_done),       32'(m_done));
      chk("load_count",      32'(load_count),      32'(m_count));
   endtask

   // Let the clock edge happen and advance the model by the rules of the current mode.
   task automatic commit();
      bit fin;
      @(posedge clk);
      m_fv = e_facc;
      if (e_facc) m_fi = exp_mem[fetch_addr];
      fin = e_acc && (load_last || m_ptr == DEPTH - 1);
      if (e_acc) exp_mem[m_ptr] = load_data;
      if (load_start) begin
         m_mode = 1; m_ptr = 0;
      end else if (fin) begin
         m_count = m_ptr + 1; m_ptr = 0; m_mode = 2;
      end else if (e_acc) begin
         m_ptr++;
      end
      m_done = fin;
   endtask

   // Assert reset between edges (after a drive), check outputs clear without a clock, then release.
   task automatic async_reset();
      #2;
      rst = 1'b1;
      #1;
      chk("rst_state",       32'(state),           32'd0);
      chk("rst_load_ready",  32'(load_ready),      32'd0);
      chk("rst_mem_en",      32'(mem_en_write),    32'd0);
      chk("rst_addr_write",  32'(mem_addr_write),  32'd0);
      chk("rst_instr_write", 32'(mem_instr_write), 32'd0);
      chk("rst_fetch_ready", 32'(fetch_ready),     32'd0);
      chk("rst_fetch_valid", 32'(fetch_valid),     32'd0);
      chk("rst_fetch_instr", 32'(fetch_instr),     32'd0);
      chk("rst_load_done",   32'(load_done),       32'd0);
      chk("rst_load_count",  32'(load_count),      32'd0);
      chk("rst_cpu_run",     32'(cpu_run),         32'd0);
      chk("rst_addr_read",   32'(mem_addr_read),   32'd0);
      model_reset();
      load_start = 0; load_valid = 0; load_data = '0; load_last = 0; fetch_req = 0; fetch_addr = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < int'(DEPTH); i++) exp_mem[i] = '0;
      model_reset();
      e_acc = 0; e_facc = 0;
      rst = 1'b1;
      load_start = 0; load_valid = 0; load_data = '0; load_last = 0; fetch_req = 0; fetch_addr = '0;

      // start, 4-word program, then fetches of 2, 0, 3 back-to-back
      vecs[0] = mkv(1, 0, 0,      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[1] = mkv(0, 1, 'h1001, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
      vecs[2] = mkv(0, 1, 'h1002, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0);
      vecs[3] = mkv(0, 1, 'h1003, 0, 0, 0, 1, 1, 1, 2, 0, 0, 0, 0, 0);
      vecs[4] = mkv(0, 1, 'h1004, 1, 0, 0, 1, 1, 1, 3, 0, 0, 0, 0, 0);
      vecs[5] = mkv(0, 0, 0,      0, 1, 2, 2, 0, 0, 0, 1, 4, 2, 0, 0);
      vecs[6] = mkv(0, 0, 0,      0, 1, 0, 2, 0, 0, 0, 0, 4, 0, 1, 'h1003);
      vecs[7] = mkv(0, 0, 0,      0, 1, 3, 2, 0, 0, 0, 0, 4, 3, 1, 'h1001);
      vecs[8] = mkv(0, 0, 0,      0, 0, 0, 2, 0, 0, 0, 0, 4, 0, 1, 'h1004);
      vecs[9] = mkv(0, 0, 0,      0, 0, 0, 2, 0, 0, 0, 0, 4, 0, 0, 'h1004);

      #3;
      chk("init_state",       32'(state),        32'd0);
      chk("init_load_count",  32'(load_count),   32'd0);
      chk("init_fetch_valid", 32'(fetch_valid),  32'd0);
      chk("init_mem_en",      32'(mem_en_write), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].st, vecs[i].lv, vecs[i].ld, vecs[i].ll, vecs[i].fr, vecs[i].fa);
         chk($sformatf("vec%0d_state", i),      32'(state),          32'(vecs[i].e_st));
         chk($sformatf("vec%0d_ready", i),      32'(load_ready),     32'(vecs[i].e_rdy));
         chk($sformatf("vec%0d_en", i),         32'(mem_en_write),   32'(vecs[i].e_en));
         chk($sformatf("vec%0d_addr_w", i),     32'(mem_addr_write), 32'(vecs[i].e_aw));
         chk($sformatf("vec%0d_done", i),       32'(load_done),      32'(vecs[i].e_done));
         chk($sformatf("vec%0d_count", i),      32'(load_count),     32'(vecs[i].e_cnt));
         chk($sformatf("vec%0d_addr_r", i),     32'(mem_addr_read),  32'(vecs[i].e_ar));
         chk($sformatf("vec%0d_fvalid", i),     32'(fetch_valid),    32'(vecs[i].e_fv));
         chk($sformatf("vec%0d_finstr", i),     32'(fetch_instr),    32'(vecs[i].e_fi));
         commit();
      end

      // Full-depth load with no last marker: overflow guard ends it
      drive(1, 0, '0, 0, 0, '0); commit();
      for (int i = 0; i < int'(DEPTH); i++) begin
         drive(0, 1, DW'($urandom), 0, 0, '0);
         if (i == int'(DEPTH) - 1) chk("full_last_addr", 32'(mem_addr_write), 32'd255);
         commit();
      end
      drive(0, 1, 16'hdead, 0, 1, 8'd7);
      chk("full_257_en",    32'(mem_en_write), 32'd0);
      chk("full_257_ready", 32'(load_ready),   32'd0);
      chk("full_done",      32'(load_done),    32'd1);
      chk("full_count",     32'(load_count),   32'd256);
      chk("full_state",     32'(state),        32'd2);
      commit();
      drive(0, 0, '0, 0, 0, '0);
      chk("full_done_once", 32'(load_done), 32'd0);
      commit();

      // Restart during a load at wr_ptr=5 drops the concurrent beat
      drive(1, 0, '0, 0, 0, '0); commit();
      for (int i = 0; i < 5; i++) begin
         drive(0, 1, DW'(16'h2000 + i), 0, 0, '0); commit();
      end
      drive(1, 1, 16'hbeef, 0, 0, '0);
      chk("restart_drop_en", 32'(mem_en_write), 32'd0);
      chk("restart_count",   32'(load_count),   32'd256);
      commit();
      drive(0, 1, 16'h5a5a, 1, 0, '0);
      chk("restart_en",   32'(mem_en_write),   32'd1);
      chk("restart_addr", 32'(mem_addr_write), 32'd0);
      commit();
      drive(0, 0, '0, 0, 0, '0);
      chk("restart_count1", 32'(load_count), 32'd1);
      commit();

      // Load start in RUN alongside a fetch of address 1
      drive(1, 0, '0, 0, 1, 8'd1);
      chk("run_start_fready", 32'(fetch_ready),   32'd1);
      chk("run_start_raddr",  32'(mem_addr_read), 32'd1);
      commit();
      drive(0, 0, '0, 0, 1, 8'd2);
      chk("run_start_fvalid", 32'(fetch_valid),   32'd1);
      chk("run_start_finstr", 32'(fetch_instr),   32'(exp_mem[1]));
      chk("run_start_fready2", 32'(fetch_ready),  32'd0);
      chk("run_start_state",  32'(state),         32'd1);
      chk("run_start_cpu",    32'(cpu_run),       32'd0);
      commit();

      // Reset mid-load at wr_ptr=10, then fetches must be ignored
      for (int i = 0; i < 10; i++) begin
         drive(0, 1, DW'(16'h3000 + i), 0, 0, '0); commit();
      end
      drive(0, 1, 16'h300a, 0, 1, 8'd3);
      chk("preabort_addr", 32'(mem_addr_write), 32'd10);
      async_reset();
      drive(0, 0, '0, 0, 1, 8'd4);
      chk("postrst_fready", 32'(fetch_ready), 32'd0);
      commit();
      drive(0, 0, '0, 0, 0, '0);
      chk("postrst_fvalid", 32'(fetch_valid), 32'd0);
      commit();

      // Random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         drive(($urandom % 40) == 0, ($urandom % 10) < 6, DW'($urandom),
               ($urandom % 16) == 0, ($urandom % 2) == 1, AW'($urandom));
         if (($urandom % 500) == 0) async_reset();
         else commit();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
